mano_timing_unit: RTL and testbench



---
 rtl/mano_pkg.sv | 22 ++
 rtl/mano_timing_unit_if.sv | 33 +++
 rtl/onehot_dec.sv | 18 +
 rtl/mano_timing_unit.sv | 99 +++++++++
 tb/tb_mano_timing_unit.sv | 125 ++++++++++++
 5 files changed

// File: rtl/mano_pkg.sv
// Shared constants for the basic-computer timing front end: widths, IR field
// positions and the memory-reference opcode encoding.
package mano_pkg;

  localparam int unsigned SC_WIDTH = 4;
  localparam int unsigned T_WIDTH  = 16;
  localparam int unsigned IR_WIDTH = 16;
  localparam int unsigned OPC_LSB  = 12;
  localparam int unsigned I_BIT    = IR_WIDTH - 1;

  typedef enum logic [2:0] {
    OPC_AND    = 3'd0,
    OPC_ADD    = 3'd1,
    OPC_LDA    = 3'd2,
    OPC_STA    = 3'd3,
    OPC_BUN    = 3'd4,
    OPC_BSA    = 3'd5,
    OPC_ISZ    = 3'd6,
    OPC_REG_IO = 3'd7
  } opcode_e;

endpackage

// File: rtl/mano_timing_unit_if.sv
// Control/status bundle between the sequence-control logic (master) and the
// timing unit (slave).
interface mano_timing_unit_if #(
  parameter int unsigned SC_WIDTH = mano_pkg::SC_WIDTH,
  parameter int unsigned T_WIDTH  = mano_pkg::T_WIDTH,
  parameter int unsigned IR_WIDTH = mano_pkg::IR_WIDTH
);

  logic                start;
  logic                halt;
  logic                sc_clr;
  logic                sc_inc;
  logic                ir_load;
  logic [IR_WIDTH-1:0] ir_in;
  logic [T_WIDTH-1:0]  T;
  logic [7:0]          D;
  logic                I;
  logic                running;
  logic [SC_WIDTH-1:0] sc;
  logic                sc_wrap;
  logic                cycle_done;

  modport master (
    output start, halt, sc_clr, sc_inc, ir_load, ir_in,
    input  T, D, I, running, sc, sc_wrap, cycle_done
  );

  modport slave (
    input  start, halt, sc_clr, sc_inc, ir_load, ir_in,
    output T, D, I, running, sc, sc_wrap, cycle_done
  );

endinterface

// File: rtl/onehot_dec.sv
// Binary to one-hot decoder with enable; output is all-zero when disabled.
module onehot_dec #(
  parameter  int unsigned N = 3,
  localparam int unsigned M = 1 << N
) (
  input  logic         en_i,
  input  logic [N-1:0] bin_i,
  output logic [M-1:0] onehot_o
);

  always_comb begin
    onehot_o = '0;
    if (en_i) begin
      onehot_o[bin_i] = 1'b1;
    end
  end

endmodule

// File: rtl/mano_timing_unit.sv
// Start/stop flip-flop, sequence counter and IR opcode/I latch, with one-hot
// timing (T) and opcode (D) decode for the basic-computer control unit.
module mano_timing_unit import mano_pkg::*; #(
  parameter int unsigned SC_WIDTH = mano_pkg::SC_WIDTH,
  parameter int unsigned T_WIDTH  = mano_pkg::T_WIDTH,
  parameter int unsigned IR_WIDTH = mano_pkg::IR_WIDTH,
  parameter int unsigned OPC_LSB  = mano_pkg::OPC_LSB
) (
  input logic                clk,
  input logic                rst_n,
  mano_timing_unit_if.slave  bus
);

  logic                s_q, s_d;
  logic [SC_WIDTH-1:0] sc_q, sc_d;
  opcode_e             opc_q, opc_d;
  logic                ibit_q, ibit_d;
  logic                wrap_q, wrap_d;
  logic                done_q, done_d;

  // Only the opcode and I fields of IR are consumed here; the address field
  // is kept by the datapath.
  logic unused_ir_addr;
  assign unused_ir_addr = ^bus.ir_in[OPC_LSB-1:0];

  always_comb begin
    s_d    = s_q;
    sc_d   = sc_q;
    opc_d  = opc_q;
    ibit_d = ibit_q;
    wrap_d = wrap_q;
    done_d = 1'b0;

    if (s_q && bus.halt) begin
      s_d  = 1'b0;
      sc_d = '0;
    end else if (!s_q && bus.start && !bus.halt) begin
      s_d    = 1'b1;
      sc_d   = '0;
      wrap_d = 1'b0;
    end else if (s_q) begin
      // Clear beats increment, so a simultaneous clr/inc never flags a wrap.
      if (bus.sc_clr) begin
        sc_d   = '0;
        done_d = 1'b1;
      end else if (bus.sc_inc) begin
        sc_d = sc_q + 1'b1;
        if (&sc_q) begin
          wrap_d = 1'b1;
        end
      end
      if (bus.ir_load) begin
        opc_d  = opcode_e'(bus.ir_in[OPC_LSB +: 3]);
        ibit_d = bus.ir_in[IR_WIDTH-1];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      s_q    <= 1'b0;
      sc_q   <= '0;
      opc_q  <= OPC_AND;
      ibit_q <= 1'b0;
      wrap_q <= 1'b0;
      done_q <= 1'b0;
    end else begin
      s_q    <= s_d;
      sc_q   <= sc_d;
      opc_q  <= opc_d;
      ibit_q <= ibit_d;
      wrap_q <= wrap_d;
      done_q <= done_d;
    end
  end

  onehot_dec #(
    .N (SC_WIDTH)
  ) u_t_dec (
    .en_i     (s_q),
    .bin_i    (sc_q),
    .onehot_o (bus.T)
  );

  onehot_dec #(
    .N (3)
  ) u_d_dec (
    .en_i     (1'b1),
    .bin_i    (opc_q),
    .onehot_o (bus.D)
  );

  assign bus.I          = ibit_q;
  assign bus.running    = s_q;
  assign bus.sc         = sc_q;
  assign bus.sc_wrap    = wrap_q;
  assign bus.cycle_done = done_q;

endmodule

// File: tb/tb_mano_timing_unit.sv
// Scoreboard bench for mano_timing_unit: directed per-cycle stimulus pushes the
// expected post-edge state; a negedge monitor pops and compares.
module tb_mano_timing_unit;
  import mano_pkg::*;

  logic clk = 1'b0;
  logic rst_n;
  int   cyc = 0;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  mano_timing_unit_if bus ();

  mano_timing_unit dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  typedef struct {
    string       name;
    int          cyc;
    logic [15:0] t;
    logic [7:0]  d;
    logic        i;
    logic        run;
    logic [3:0]  sc;
    logic        wrap;
    logic        done;
  } exp_t;

  exp_t q[$];

  task automatic step(input logic rst, input logic st, input logic hl, input logic clr,
                      input logic inc, input logic ld, input logic [15:0] ir,
                      input string name, input logic [15:0] t, input logic [7:0] d,
                      input logic i, input logic run, input logic [3:0] sc,
                      input logic wrap, input logic done);
    exp_t e;
    @(negedge clk);
    rst_n       = rst;
    bus.start   = st;
    bus.halt    = hl;
    bus.sc_clr  = clr;
    bus.sc_inc  = inc;
    bus.ir_load = ld;
    bus.ir_in   = ir;
    e.name = name;
    e.cyc  = cyc + 1;
    e.t    = t;
    e.d    = d;
    e.i    = i;
    e.run  = run;
    e.sc   = sc;
    e.wrap = wrap;
    e.done = done;
    q.push_back(e);
  endtask

  // Monitor: compare every entry whose target edge has already happened.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      while (q.size() > 0 && q[0].cyc <= cyc) begin
        e = q.pop_front();
        checks++;
        if (e.cyc != cyc ||
            {bus.T, bus.D, bus.I, bus.running, bus.sc, bus.sc_wrap, bus.cycle_done} !==
            {e.t, e.d, e.i, e.run, e.sc, e.wrap, e.done}) begin
          errors++;
          $display("FAIL %s cyc=%0d got T=%h D=%h I=%b run=%b sc=%0d wrap=%b done=%b exp T=%h D=%h I=%b run=%b sc=%0d wrap=%b done=%b",
                   e.name, cyc, bus.T, bus.D, bus.I, bus.running, bus.sc, bus.sc_wrap,
                   bus.cycle_done, e.t, e.d, e.i, e.run, e.sc, e.wrap, e.done);
        end
      end
    end
  end

  initial begin
    //   rst st hl clr inc ld ir        name          T        D      I  run sc wrap done
    step(0, 1, 0, 0, 1, 0, 16'h0000, "reset0",     16'h0000, 8'h01, 0, 0, 0, 0, 0);
    step(0, 1, 0, 0, 1, 0, 16'h0000, "reset1",     16'h0000, 8'h01, 0, 0, 0, 0, 0);
    step(1, 1, 0, 0, 0, 0, 16'h0000, "start",      16'h0001, 8'h01, 0, 1, 0, 0, 0);
    step(1, 0, 0, 0, 1, 0, 16'h0000, "cnt1",       16'h0002, 8'h01, 0, 1, 1, 0, 0);
    step(1, 0, 0, 0, 1, 1, 16'hB123, "ir_load",    16'h0004, 8'h08, 1, 1, 2, 0, 0);
    step(1, 0, 0, 0, 1, 0, 16'h0000, "cnt3",       16'h0008, 8'h08, 1, 1, 3, 0, 0);
    step(1, 1, 0, 0, 1, 0, 16'h0000, "start_busy", 16'h0010, 8'h08, 1, 1, 4, 0, 0);
    step(1, 0, 0, 0, 1, 0, 16'h0000, "cnt5",       16'h0020, 8'h08, 1, 1, 5, 0, 0);
    step(1, 0, 0, 1, 1, 0, 16'h0000, "clr_prio",   16'h0001, 8'h08, 1, 1, 0, 0, 1);
    step(1, 0, 0, 0, 0, 0, 16'h0000, "done_pulse", 16'h0001, 8'h08, 1, 1, 0, 0, 0);
    for (int k = 1; k <= 16; k++) begin
      step(1, 0, 0, 0, 1, 0, 16'h0000, "wrap_run", 16'(1 << (k % 16)), 8'h08, 1, 1,
           4'(k % 16), (k == 16), 0);
    end
    step(1, 0, 0, 0, 1, 0, 16'h0000, "sticky1",    16'h0002, 8'h08, 1, 1, 1, 1, 0);
    step(1, 0, 0, 0, 1, 0, 16'h0000, "sticky2",    16'h0004, 8'h08, 1, 1, 2, 1, 0);
    step(1, 0, 0, 0, 1, 0, 16'h0000, "to_t3",      16'h0008, 8'h08, 1, 1, 3, 1, 0);
    step(1, 0, 1, 0, 1, 0, 16'h0000, "halt",       16'h0000, 8'h08, 1, 0, 0, 1, 0);
    step(1, 0, 0, 0, 1, 0, 16'h0000, "idle_inc",   16'h0000, 8'h08, 1, 0, 0, 1, 0);
    step(1, 0, 0, 0, 0, 1, 16'h7000, "idle_ld",    16'h0000, 8'h08, 1, 0, 0, 1, 0);
    step(1, 0, 0, 1, 0, 0, 16'h0000, "idle_clr",   16'h0000, 8'h08, 1, 0, 0, 1, 0);
    step(1, 1, 1, 0, 0, 0, 16'h0000, "start_halt", 16'h0000, 8'h08, 1, 0, 0, 1, 0);
    step(1, 1, 0, 0, 0, 0, 16'h0000, "restart",    16'h0001, 8'h08, 1, 1, 0, 0, 0);
    step(1, 0, 0, 0, 1, 1, 16'h6000, "ld_isz",     16'h0002, 8'h40, 0, 1, 1, 0, 0);
    step(1, 0, 0, 0, 1, 0, 16'h0000, "isz_t2",     16'h0004, 8'h40, 0, 1, 2, 0, 0);
    step(1, 0, 0, 0, 1, 0, 16'h0000, "isz_t3",     16'h0008, 8'h40, 0, 1, 3, 0, 0);
    step(1, 0, 0, 0, 1, 0, 16'h0000, "isz_t4",     16'h0010, 8'h40, 0, 1, 4, 0, 0);
    step(0, 0, 0, 0, 1, 0, 16'h0000, "rst_mid",    16'h0000, 8'h01, 0, 0, 0, 0, 0);

    repeat (2) @(posedge clk);
    #1;
    checks++;
    if (q.size() != 0) begin
      errors++;
      $display("FAIL drain got %0d pending entries, required 0", q.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
